// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, the zero-register index and counter width.
// No timing or flow control of its own.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } hz_state_t;

    localparam logic [4:0] XZR_IDX = 5'd31;
    localparam int         CNT_W   = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for hazard performance statistics.
// Latency: count updates one cycle after inc; sticks at all-ones.
// No backpressure: inc is sampled every cycle.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: memory-wait freeze, load-use stall, branch flush.
// Latency: enables/flush are combinational from state and current inputs.
// Backpressure: a pending dmem access freezes every pipeline register.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int TIMEOUT_LIMIT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             MemRead_ex,
    input  logic [4:0]       Rd_ex,
    input  logic [4:0]       regA_id,
    input  logic [4:0]       regB_id,
    input  logic             useA_id,
    input  logic             useB_id,
    input  logic             branch_taken_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int WAIT_W = (TIMEOUT_LIMIT < 2) ? 1 : $clog2(TIMEOUT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_LIMIT);

    hz_state_t         state;
    hz_state_t         state_nxt;
    logic              load_use;
    logic              lu_stall;
    logic              lu_stalled;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;

    assign load_use = MemRead_ex && (Rd_ex != XZR_IDX) &&
                      ((useA_id && (Rd_ex == regA_id)) ||
                       (useB_id && (Rd_ex == regB_id)));

    assign wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);

    always_comb begin
        state_nxt   = state;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        lu_stall    = 1'b0;
        if (reset_n) begin
            unique case (state)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        state_nxt = MEMWAIT;
                    end else if (branch_taken_ex) begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use && !lu_stalled) begin
                        // Second back-to-back hit means the bubble already resolved it.
                        {idex_en, exmem_en, memwb_en} = 3'b111;
                        idex_bubble = 1'b1;
                        lu_stall    = 1'b1;
                    end else begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    end
                end
                MEMWAIT: begin
                    if (dmem_ready) begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            lu_stalled  <= 1'b0;
        end else begin
            state      <= state_nxt;
            lu_stalled <= lu_stall;
            if (state == RUN) begin
                wait_cnt <= '0;
            end else if (!dmem_ready) begin
                wait_cnt <= wait_nxt;
                if (wait_nxt == WAIT_MAX) begin
                    mem_timeout <= 1'b1;
                end
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (~pc_en),
        .count   (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (ifid_flush),
        .count   (flush_count)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with a short memory timeout.
module tb_hazard_controller;

    localparam int TL = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        MemRead_ex;
    logic [4:0]  Rd_ex, regA_id, regB_id;
    logic        useA_id, useB_id, branch_taken_ex, dmem_req, dmem_ready;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble;
    logic [15:0] stall_cycles, flush_count;
    logic        mem_timeout;
    logic [6:0]  ctl;

    int checks   = 0;
    int failures = 0;

    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble};

    always #5 clk = ~clk;

    hazard_controller #(.TIMEOUT_LIMIT(TL)) dut (
        .clk(clk), .reset_n(reset_n), .MemRead_ex(MemRead_ex), .Rd_ex(Rd_ex),
        .regA_id(regA_id), .regB_id(regB_id), .useA_id(useA_id), .useB_id(useB_id),
        .branch_taken_ex(branch_taken_ex), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_timeout(mem_timeout)
    );

    task automatic clear_inputs();
        MemRead_ex = 0; Rd_ex = 0; regA_id = 0; regB_id = 0;
        useA_id = 0; useB_id = 0; branch_taken_ex = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        clear_inputs();
        branch_taken_ex = 1;
        #2;
        checks++; if (ctl !== 7'b0000000) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b0); end
        next_cycle();
        checks++; if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_count); end
        checks++; if (mem_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", mem_timeout); end
        clear_inputs();
        @(negedge clk); reset_n = 1;
        next_cycle();
    endtask

    task automatic test_idle();
        clear_inputs();
        @(negedge clk);
        checks++; if (ctl !== 7'b1111100) begin failures++; $display("FAIL idle_ctl got=%b exp=%b", ctl, 7'b1111100); end
        next_cycle();
        dmem_ready = 1;
        @(negedge clk);
        checks++; if (ctl !== 7'b1111100) begin failures++; $display("FAIL ready_no_req got=%b exp=%b", ctl, 7'b1111100); end
        next_cycle();
        dmem_ready = 0;
        @(negedge clk);
        checks++; if (ctl !== 7'b1111100) begin failures++; $display("FAIL ready_no_req_after got=%b exp=%b", ctl, 7'b1111100); end
        next_cycle();
    endtask

    task automatic test_load_use();
        MemRead_ex = 1; Rd_ex = 5; regA_id = 5; useA_id = 1;
        @(negedge clk);
        checks++; if (ctl !== 7'b0011101) begin failures++; $display("FAIL lu_ctl got=%b exp=%b", ctl, 7'b0011101); end
        next_cycle();
        checks++; if (stall_cycles !== 16'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cycles); end
        clear_inputs();
        @(negedge clk);
        checks++; if (ctl !== 7'b1111100) begin failures++; $display("FAIL lu_release got=%b exp=%b", ctl, 7'b1111100); end
        next_cycle();
        // Hazard via regB held for two cycles: only the first one stalls.
        MemRead_ex = 1; Rd_ex = 9; regB_id = 9; useB_id = 1;
        @(negedge clk);
        checks++; if (ctl !== 7'b0011101) begin failures++; $display("FAIL lu_b_ctl got=%b exp=%b", ctl, 7'b0011101); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== 7'b1111100) begin failures++; $display("FAIL lu_one_cycle got=%b exp=%b", ctl, 7'b1111100); end
        next_cycle();
        checks++; if (stall_cycles !== 16'd2) begin failures++; $display("FAIL lu_b_stall_cnt got=%0d exp=2", stall_cycles); end
        clear_inputs();
    endtask

    task automatic test_no_hazard();
        MemRead_ex = 1; Rd_ex = 31; regA_id = 31; useA_id = 1;
        @(negedge clk);
        checks++; if (ctl !== 7'b1111100) begin failures++; $display("FAIL xzr_ctl got=%b exp=%b", ctl, 7'b1111100); end
        next_cycle();
        Rd_ex = 5; regA_id = 5; useA_id = 0;
        @(negedge clk);
        checks++; if (ctl !== 7'b1111100) begin failures++; $display("FAIL unused_ctl got=%b exp=%b", ctl, 7'b1111100); end
        next_cycle();
        checks++; if (stall_cycles !== 16'd2) begin failures++; $display("FAIL nohaz_stall_cnt got=%0d exp=2", stall_cycles); end
        clear_inputs();
    endtask

    task automatic test_branch();
        MemRead_ex = 1; Rd_ex = 5; regA_id = 5; useA_id = 1; branch_taken_ex = 1;
        @(negedge clk);
        checks++; if (ctl !== 7'b1111111) begin failures++; $display("FAIL br_ctl got=%b exp=%b", ctl, 7'b1111111); end
        next_cycle();
        checks++; if (flush_count !== 16'd1) begin failures++; $display("FAIL br_flush_cnt got=%0d exp=1", flush_count); end
        checks++; if (stall_cycles !== 16'd2) begin failures++; $display("FAIL br_stall_cnt got=%0d exp=2", stall_cycles); end
        clear_inputs();
    endtask

    task automatic test_memwait();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                branch_taken_ex = 1; MemRead_ex = 1; Rd_ex = 5; regA_id = 5; useA_id = 1;
            end else begin
                branch_taken_ex = 0; MemRead_ex = 0;
            end
            @(negedge clk);
            checks++; if (ctl !== 7'b0000000) begin failures++; $display("FAIL mw_frozen[%0d] got=%b exp=%b", i, ctl, 7'b0); end
            next_cycle();
        end
        clear_inputs();
        dmem_req = 1; dmem_ready = 1;
        @(negedge clk);
        checks++; if (ctl !== 7'b1111100) begin failures++; $display("FAIL mw_ready got=%b exp=%b", ctl, 7'b1111100); end
        next_cycle();
        checks++; if (stall_cycles !== 16'd5) begin failures++; $display("FAIL mw_stall_cnt got=%0d exp=5", stall_cycles); end
        checks++; if (flush_count !== 16'd1) begin failures++; $display("FAIL mw_flush_cnt got=%0d exp=1", flush_count); end
        checks++; if (mem_timeout !== 1'b0) begin failures++; $display("FAIL mw_no_timeout got=%b exp=0", mem_timeout); end
        clear_inputs();
        @(negedge clk);
        checks++; if (ctl !== 7'b1111100) begin failures++; $display("FAIL mw_back_run got=%b exp=%b", ctl, 7'b1111100); end
        next_cycle();
    endtask

    task automatic test_timeout();
        dmem_req = 1; dmem_ready = 0;
        next_cycle();
        for (int i = 0; i < TL - 1; i++) next_cycle();
        checks++; if (mem_timeout !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", mem_timeout); end
        next_cycle();
        checks++; if (mem_timeout !== 1'b1) begin failures++; $display("FAIL to_set got=%b exp=1", mem_timeout); end
        @(negedge clk);
        checks++; if (ctl !== 7'b0000000) begin failures++; $display("FAIL to_still_wait got=%b exp=%b", ctl, 7'b0); end
        next_cycle();
        dmem_ready = 1;
        @(negedge clk);
        checks++; if (ctl !== 7'b1111100) begin failures++; $display("FAIL to_ready got=%b exp=%b", ctl, 7'b1111100); end
        next_cycle();
        clear_inputs();
        checks++; if (stall_cycles !== 16'd15) begin failures++; $display("FAIL to_stall_cnt got=%0d exp=15", stall_cycles); end
        next_cycle();
        checks++; if (mem_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", mem_timeout); end
    endtask

    task automatic test_reset_midwait();
        dmem_req = 1; dmem_ready = 0;
        next_cycle();
        next_cycle();
        reset_n = 0;
        dmem_ready = 1;
        #1;
        checks++; if (ctl !== 7'b0000000) begin failures++; $display("FAIL rst_mw_ctl got=%b exp=%b", ctl, 7'b0); end
        checks++; if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin failures++; $display("FAIL rst_mw_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_count); end
        checks++; if (mem_timeout !== 1'b0) begin failures++; $display("FAIL rst_mw_timeout got=%b exp=0", mem_timeout); end
        next_cycle();
        clear_inputs();
        @(negedge clk); reset_n = 1;
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== 7'b1111100) begin failures++; $display("FAIL rst_mw_run got=%b exp=%b", ctl, 7'b1111100); end
        next_cycle();
        dmem_req = 1;
        @(negedge clk);
        checks++; if (ctl !== 7'b0000000) begin failures++; $display("FAIL rst_mw_fresh got=%b exp=%b", ctl, 7'b0); end
        next_cycle();
        clear_inputs();
        dmem_ready = 1;
        next_cycle();
        checks++; if (stall_cycles !== 16'd1 || mem_timeout !== 1'b0) begin failures++; $display("FAIL rst_mw_fresh_cnt got=%0d/%b exp=1/0", stall_cycles, mem_timeout); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset_n = 0;
        test_reset();
        test_idle();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_memwait();
        test_timeout();
        test_reset_midwait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_LIMIT, default 255, meaning the number of MEMWAIT cycles before mem_timeout is raised.
REQ-002 SHALL have port clk  input  1  the single clock; rising edge active.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port MemRead_ex  input  1  a load is in EX.
REQ-005 SHALL have port Rd_ex  input  5  destination register of the EX instruction.
REQ-006 SHALL have ports regA_id, regB_id  input  5  ID-stage source registers.
REQ-007 SHALL have ports useA_id, useB_id  input  1  ID instruction actually reads regA/regB.
REQ-008 SHALL have port branch_taken_ex  input  1  taken branch resolved in EX.
REQ-009 SHALL have ports dmem_req, dmem_ready  input  1  MEM-stage access request and its completion handshake.
REQ-010 SHALL have ports pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1  pipeline register write enables.
REQ-011 SHALL have ports ifid_flush, idex_bubble  output  1  zero the IF/ID register; insert a NOP into ID/EX.
REQ-012 SHALL have ports stall_cycles, flush_count  output  16  saturating performance counters.
REQ-013 SHALL have port mem_timeout  output  1  sticky memory-wait timeout error.

Function
REQ-014 SHALL implement FSM states RUN and MEMWAIT; the state is registered and the outputs are combinational from the state and the current inputs.
REQ-015 In RUN with dmem_req=1 and dmem_ready=0, all five enables SHALL be 0, flush/bubble SHALL be 0, and the next state SHALL be MEMWAIT.
REQ-016 MEMWAIT SHALL hold all enables at 0 until the cycle dmem_ready=1; in that cycle all enables SHALL be 1 and the next state SHALL be RUN.
REQ-017 Memory wait SHALL have the highest priority; branch and load-use conditions SHALL be ignored while the pipeline is frozen.
REQ-018 Load-use hazard = MemRead_ex & Rd_ex!=31 & ((useA_id & Rd_ex==regA_id) | (useB_id & Rd_ex==regB_id)).
REQ-019 In RUN with a load-use hazard and no branch: pc_en=0, ifid_en=0, idex_bubble=1, other enables=1; the stall lasts exactly one cycle.
REQ-020 In RUN with branch_taken_ex=1: ifid_flush=1, idex_bubble=1, all enables=1; branch SHALL override a simultaneous load-use hazard.
REQ-021 With no condition present in RUN, all enables SHALL be 1 and flush/bubble SHALL be 0.
REQ-022 stall_cycles SHALL increment by 1 on each cycle with pc_en=0 (load-use or MEMWAIT) and saturate at 16'hFFFF.
REQ-023 flush_count SHALL increment on each cycle with ifid_flush=1 and saturate at 16'hFFFF.
REQ-024 A MEMWAIT cycle counter SHALL reset on entry to MEMWAIT; when the counter reaches TIMEOUT_LIMIT, mem_timeout SHALL be set to 1 and remain 1 until reset, while the FSM keeps waiting.
REQ-025 dmem_ready asserted without dmem_req in RUN SHALL be ignored.

Reset
REQ-026 While reset_n=0: state=RUN, counters=0, mem_timeout=0, wait counter=0, all enables=0, ifid_flush=0, idex_bubble=0.
REQ-027 Reset asserted mid-MEMWAIT SHALL abort the wait immediately; after release, behaviour SHALL match a fresh start.

Structure
REQ-028 Package hazard_pkg SHALL hold the FSM state enum (RUN, MEMWAIT), XZR_IDX=5'd31 and the counter width constant (16).
REQ-029 A sub-module sat_counter (parameterised width, async active-low reset, inc input) SHALL be instantiated for stall_cycles and flush_count.

Verification
REQ-030 Bench SHALL cover: MemRead_ex=1, Rd_ex=5, regA_id=5, useA_id=1 -> one cycle with pc_en=0, ifid_en=0, idex_bubble=1; stall_cycles=1.
REQ-031 Bench SHALL cover: the same hazard with Rd_ex=31, or with useA_id=0 -> no stall, all enables=1.
REQ-032 Bench SHALL cover: branch_taken_ex=1 together with the load-use hazard -> ifid_flush=1, idex_bubble=1, pc_en=1; flush_count=1.
REQ-033 Bench SHALL cover: dmem_req=1 with dmem_ready low for 3 cycles -> enables=0 for 3 cycles, then 1 in the ready cycle; stall_cycles=3.
REQ-034 Bench SHALL cover: dmem_ready held low for TIMEOUT_LIMIT+2 cycles -> mem_timeout=1 and stays 1 after ready; cleared only by reset_n=0.
REQ-035 Bench SHALL cover: reset_n pulsed low during MEMWAIT -> all outputs take their reset values asynchronously; RUN resumes after release.
